// File: rtl/systolic_input_feeder.sv
// Input feeder for the weight-stationary systolic array: row FIFO, diagonal
// skew chains, and the zero-row drain that flushes the array after each batch.

module systolic_input_feeder_lane #(
    parameter int STAGES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_shift,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);
    logic [STAGES-1:0][7:0] r_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe <= '0;
        end else if (i_shift) begin
            r_pipe[0] <= i_d;
            for (int k = 1; k < STAGES; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign o_q = r_pipe[STAGES-1];
endmodule

module systolic_input_feeder #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int DRAIN = 2*N-1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*N-1:0]           in_data,
    input  logic                     in_last,
    output logic [8*N-1:0]           array_in_o,
    output logic                     array_en_o,
    output logic                     busy_o,
    output logic                     flush_done_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DCW = $clog2(DRAIN + 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    state_t           r_state, w_state_nxt;
    logic [8*N-1:0]   r_mem_data [DEPTH];
    logic             r_mem_last [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic             r_in_ready;
    logic [DCW-1:0]   r_drain, w_drain_nxt, w_drain_inc;
    logic             r_en, r_done;
    logic             w_push, w_pop, w_shift, w_zero, w_done;
    logic [8*N-1:0]   w_head_data, w_shift_row;
    logic             w_head_last;

    assign w_push      = in_valid & r_in_ready;
    assign w_head_data = r_mem_data[r_rptr];
    assign w_head_last = r_mem_last[r_rptr];
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_drain_inc = r_drain + DCW'(1);

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= in_data;
            r_mem_last[r_wptr] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_drain <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_en    <= w_shift;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = '0;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        w_zero      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE, S_STREAM: begin
                // An empty FIFO in STREAM is a bubble: chains hold, no zero row.
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_shift     = 1'b1;
                    w_state_nxt = w_head_last ? S_FLUSH : S_STREAM;
                end
            end
            S_FLUSH: begin
                w_shift     = 1'b1;
                w_zero      = 1'b1;
                w_drain_nxt = w_drain_inc;
                if (w_drain_inc == DCW'(DRAIN)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shift_row = w_zero ? '0 : w_head_data;

    // Lane g carries g+1 registers, giving the diagonal skew at the array edge.
    for (genvar g = 0; g < N; g++) begin : g_lane
        systolic_input_feeder_lane #(.STAGES(g + 1)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .i_shift (w_shift),
            .i_d     (w_shift_row[8*g +: 8]),
            .o_q     (array_in_o[8*g +: 8])
        );
    end

    assign in_ready     = r_in_ready;
    assign array_en_o   = r_en;
    assign flush_done_o = r_done;
    assign fifo_count_o = r_count;
    // The done cycle still counts as busy so busy falls the cycle after it.
    assign busy_o       = (r_state != S_IDLE) || (r_count != '0) || r_done;
endmodule
